// File: rtl/store_narrow_unit.sv
// Store narrowing unit: writes SW/SH/SB into word-only data memory,
// using read-modify-write for sub-word stores; flags misalignment and lossy narrowing.
module store_narrow_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        narrow_ovf,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    WR,
    DN
  } state_t;

  typedef enum logic [1:0] {
    OP_SW  = 2'b00,
    OP_SH  = 2'b01,
    OP_SB  = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  state_t      state;
  state_t      state_nxt;
  op_t         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] wdata_hold_q;
  logic        err_q;
  logic        ovf_q;

  logic        accept;
  logic        req_err;
  logic        req_ovf;
  logic [31:0] merged;

  assign accept = (state == IDLE) && start;

  // Request classification uses the raw inputs; only registered results reach outputs.
  always_comb begin
    req_err = 1'b0;
    req_ovf = 1'b0;
    case (op_t'(op))
      OP_SW:   req_err = (addr[1:0] != 2'b00);
      OP_SH: begin
        req_err = addr[0];
        req_ovf = (wdata[31:16] != {16{wdata[15]}});
      end
      OP_SB:   req_ovf = (wdata[31:8] != {24{wdata[7]}});
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_err)
            state_nxt = DN;
          else if (op_t'(op) == OP_SW)
            state_nxt = WR;
          else
            state_nxt = RD;
        end
      end
      RD:      state_nxt = WT;
      WT:      state_nxt = WR;
      WR:      state_nxt = DN;
      DN:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane merge of the fetched word with the narrowed store data (little-endian lanes).
  always_comb begin
    merged = merge_q;
    case (op_q)
      OP_SW: merged = wdata_q;
      OP_SH: begin
        if (addr_q[1])
          merged[31:16] = wdata_q[15:0];
        else
          merged[15:0]  = wdata_q[15:0];
      end
      OP_SB: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      default: merged = merge_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= OP_SW;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      wdata_hold_q <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= op_t'(op);
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= req_err;
        ovf_q   <= req_ovf && !req_err;
      end
      if (state == WT)
        merge_q <= mem_rdata;
      if (state == WR)
        wdata_hold_q <= merged;
    end
  end

  // Write data is the live merge during WR and the last written word otherwise.
  assign mem_wdata  = (state == WR) ? merged : wdata_hold_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_we     = (state == WR);
  assign busy       = (state != IDLE);
  assign done       = (state == DN);
  assign err        = (state == DN) && err_q;
  assign narrow_ovf = (state == DN) && ovf_q;

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-side companion to the load/immediate sign-extension path in the multicycle CPU. Narrows a 32-bit register value to byte, halfword or word and writes it into word-only data memory. SB/SH use a read-modify-write sequence. Reports misalignment, and flags when the discarded upper bits are not a pure sign extension of the stored field. Sits between the datapath's store controls and the data memory port.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 SW, 01 SH, 10 SB, 11 reserved.
- addr  in  32  byte address; sampled with start.
- wdata  in  32  register value to store; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned address or reserved op.
- narrow_ovf  out  1  valid with done; upper bits lost are not a sign extension.
- mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00}.
- mem_we  out  1  word write enable.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  read data; valid one cycle after mem_addr is presented.

## Operation
- FSM states: IDLE, RD, WT, WR, DN.
- IDLE + start: latch op, addr and wdata into op_q, addr_q and wdata_q. Next state by op:
  - Error (reserved op, SW with addr[1:0]≠0, or SH with addr[0]=1) → DN with err=1.
  - SW → WR.
  - SH or SB → RD.
- RD → WT → WR → DN → IDLE, unconditionally.
- WT: capture mem_rdata into merge_q.
- WR: mem_we=1 for exactly one cycle, with mem_wdata as follows:
  - SW: wdata_q.
  - SB: merge_q with byte lane k=addr_q[1:0] (bits 8k+7:8k) replaced by wdata_q[7:0].
  - SH: merge_q with half lane h=addr_q[1] (bits 16h+15:16h) replaced by wdata_q[15:0].
  - Little-endian lane numbering.
- DN: done=1 for one cycle.
  - err=1 only on the error path; on that path no write ever occurs.
  - narrow_ovf: SB sets it when wdata_q[31:8] ≠ {24{wdata_q[7]}`}`. SH sets it when wdata_q[31:16] ≠ {16{wdata_q[15]}}. SW and error paths force it to 0.
  - narrow_ovf is informational only; the write still happens.
- start while busy is ignored. It is not queued.
- start in the DN cycle is ignored. A new request is accepted only in IDLE.
- err and narrow_ovf are 0 in every cycle except DN.

## Timing
- Reset: state=IDLE; busy=0, done=0, err=0, narrow_ovf=0, mem_we=0, mem_addr=0, mem_wdata=0; internal registers cleared.
- rst during any state: IDLE on the next edge. mem_we deasserts that edge. No done pulse. The in-flight store is abandoned.
- start accepted at cycle T. Latencies:
  - SW: WR at T+1, done at T+2, IDLE at T+3.
  - SH/SB: RD at T+1, WT at T+2 (mem_rdata sampled), WR at T+3, done at T+4, IDLE at T+5.
  - Error: DN at T+1 (done=1, err=1), IDLE at T+2.
- mem_addr holds the latched word address from T+1 until the next accepted start. mem_wdata holds its WR value until the next WR.
- All outputs are registered or decoded from state only. No combinational path from start, op, addr or wdata to any output.
- Back-to-back: the next start is sampled in IDLE, at T+3 for SW.

## Test plan
- SW aligned: memory[0x10]=0xDEADBEEF. start with op=00, addr=0x10, wdata=0x12345678 → single mem_we at T+1 with data 0x12345678; done at T+2; err=0, narrow_ovf=0.
- SB all lanes: memory word=0xAABBCCDD. SB wdata=0x00000011 to addr 0x20, 0x21, 0x22, 0x23 → writes 0xAABBCC11, 0xAABB11DD, 0xAA11CCDD, 0x11BBCCDD; done at T+4 each time.
- SH with overflow flag: memory=0xAABBCCDD.
  - SH addr=0x22, wdata=0x00018000 → write 0x8000CCDD, narrow_ovf=1.
  - Repeat with wdata=0xFFFF8000 → same write, narrow_ovf=0.
- Misaligned and reserved ops: SH addr=0x21, SW addr=0x22, op=11 → each gives done at T+1 with err=1, and mem_we never asserts.
- Busy/ignore: pulse start again at T+1 and at T+4 during an SB → exactly one write and one done. A start at T+5 is accepted.
- Reset mid-op: assert rst in the WT cycle of an SB → IDLE next edge; no mem_we; no done; all outputs at reset values. A new SW then completes normally.
